mem_access_ctrl: RTL and testbench

- Bus-master stage between the ARM control unit / datapath and the 256-byte big-endian RAM.
- Converts a single-cycle CPU memory request into the RAM's asynchronous Enable/MFC four-phase handshake.
- Splits doubleword accesses into two word accesses, zero-extends byte/halfword reads, and flags misaligned requests.
- Never assumes a fixed RAM response time.

---
 rtl/mem_pkg.sv | 32 +++
 rtl/mem_access_ctrl_mfc_sync.sv | 21 ++
 rtl/mem_access_ctrl.sv | 177 +++++++++++++++++
 tb/tb_mem_access_ctrl.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared types for the memory access controller: size codes, FSM states,
// and the alignment check.
package mem_pkg;

    localparam logic [1:0] SZ_BYTE  = 2'b00;
    localparam logic [1:0] SZ_HALF  = 2'b01;
    localparam logic [1:0] SZ_WORD  = 2'b10;
    localparam logic [1:0] SZ_DWORD = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_ACCESS,
        ST_RELEASE,
        ST_FINISH
    } state_t;

    function automatic logic misaligned(input logic [1:0] sz,
                                        input logic [2:0] a);
        logic bad;
        bad = 1'b0;
        unique case (sz)
            SZ_BYTE:  bad = 1'b0;
            SZ_HALF:  bad = a[0];
            SZ_WORD:  bad = |a[1:0];
            SZ_DWORD: bad = |a[2:0];
            default:  bad = 1'b0;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/mem_access_ctrl_mfc_sync.sv
// Multi-flop synchronizer bringing the RAM's asynchronous MFC into clk.
// Chain is cleared by the synchronous active-low reset.
module mfc_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic mfc,
    output logic mfc_s
);

    logic [STAGES-1:0] chain;

    always_ff @(posedge clk) begin
        if (!reset_n) chain <= '0;
        else          chain <= {chain[STAGES-2:0], mfc};
    end

    assign mfc_s = chain[STAGES-1];

endmodule

// File: rtl/mem_access_ctrl.sv
// CPU-to-RAM bus master: single-cycle request to Enable/MFC four-phase handshake.
// Optional MFC watchdog enabled by defining MEM_TIMEOUT_EN.
module mem_access_ctrl
    import mem_pkg::*;
#(
    parameter int ADDR_W         = 8,
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [1:0]        size,
    input  logic [63:0]       wdata,
    output logic [63:0]       rdata,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              mem_enable,
    output logic              mem_rw,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [1:0]        mem_size,
    output logic [31:0]       mem_din,
    input  logic [31:0]       mem_dout,
    input  logic              mfc
);

    state_t            state;
    state_t            nstate;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [1:0]        size_q;
    logic [63:0]       wdata_q;
    logic              hi_done;
    logic              err_q;
    logic              mfc_s;
    logic              is_dw;
    logic              tmo;
    logic [31:0]       rd_mask;

    mfc_sync #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .mfc     (mfc),
        .mfc_s   (mfc_s)
    );

    assign is_dw = (size_q == SZ_DWORD);

`ifdef MEM_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] tcnt;

    // Restart the watchdog on every state change so each MFC edge gets a full budget
    always_ff @(posedge clk) begin
        if (!reset_n)
            tcnt <= '0;
        else if (nstate != state)
            tcnt <= '0;
        else if (state == ST_ACCESS || state == ST_RELEASE)
            tcnt <= tcnt + CW'(1);
    end

    assign tmo = (tcnt == CW'(TIMEOUT_CYCLES - 1)) &&
                 ((state == ST_ACCESS && !mfc_s) ||
                  (state == ST_RELEASE && mfc_s));
`else
    logic unused_tmo;
    assign unused_tmo = ^TIMEOUT_CYCLES;
    assign tmo = 1'b0;
`endif

    always_comb begin
        rd_mask = '0;
        unique case (size_q)
            SZ_BYTE: rd_mask = {24'b0, mem_dout[7:0]};
            SZ_HALF: rd_mask = {16'b0, mem_dout[15:0]};
            default: rd_mask = mem_dout;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) state <= ST_IDLE;
        else          state <= nstate;
    end

    always_comb begin
        nstate = state;
        unique case (state)
            ST_IDLE: begin
                if (req)
                    nstate = misaligned(size, addr[2:0]) ? ST_FINISH : ST_SETUP;
            end
            ST_SETUP:
                nstate = ST_ACCESS;
            ST_ACCESS: begin
                if (mfc_s)    nstate = ST_RELEASE;
                else if (tmo) nstate = ST_FINISH;
            end
            ST_RELEASE: begin
                if (!mfc_s)
                    nstate = (is_dw && !hi_done) ? ST_SETUP : ST_FINISH;
                else if (tmo)
                    nstate = ST_FINISH;
            end
            ST_FINISH:
                nstate = ST_IDLE;
            default:
                nstate = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            we_q    <= 1'b0;
            addr_q  <= '0;
            size_q  <= '0;
            wdata_q <= '0;
            hi_done <= 1'b0;
            err_q   <= 1'b0;
            rdata   <= '0;
        end else begin
            if (state == ST_IDLE && req) begin
                we_q    <= we;
                addr_q  <= addr;
                size_q  <= size;
                wdata_q <= wdata;
                hi_done <= 1'b0;
                err_q   <= misaligned(size, addr[2:0]);
            end
            if (state == ST_ACCESS && mfc_s && !we_q) begin
                if (is_dw && !hi_done) rdata[63:32] <= mem_dout;
                else if (is_dw)        rdata[31:0]  <= mem_dout;
                else                   rdata        <= {32'b0, rd_mask};
            end
            if (state == ST_RELEASE && !mfc_s && is_dw && !hi_done) begin
                addr_q  <= addr_q + ADDR_W'(4);
                hi_done <= 1'b1;
            end
            if (tmo)
                err_q <= 1'b1;
        end
    end

    always_comb begin
        busy       = 1'b0;
        done       = 1'b0;
        err        = 1'b0;
        mem_enable = 1'b0;
        mem_rw     = 1'b0;
        mem_addr   = '0;
        mem_size   = '0;
        mem_din    = '0;
        unique case (state)
            ST_SETUP, ST_ACCESS, ST_RELEASE: begin
                busy       = 1'b1;
                mem_enable = (state == ST_ACCESS);
                mem_rw     = ~we_q;
                mem_addr   = addr_q;
                mem_size   = is_dw ? SZ_WORD : size_q;
                mem_din    = (is_dw && !hi_done) ? wdata_q[63:32]
                                                 : wdata_q[31:0];
            end
            ST_FINISH: begin
                done = 1'b1;
                err  = err_q;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl with a big-endian RAM model
// that answers Enable with a random MFC delay.
module tb_mem_access_ctrl;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        req;
    logic        we;
    logic [7:0]  addr;
    logic [1:0]  size;
    logic [63:0] wdata;
    logic [63:0] rdata;
    logic        busy;
    logic        done;
    logic        err;
    logic        mem_enable;
    logic        mem_rw;
    logic [7:0]  mem_addr;
    logic [1:0]  mem_size;
    logic [31:0] mem_din;
    logic [31:0] mem_dout;
    logic        mfc;

    int checks   = 0;
    int failures = 0;

    logic [7:0] ram [256];
    int         dly;
    logic       ram_hang;

    int         rise_cnt  = 0;
    int         bad_rise  = 0;
    int         done_cnt  = 0;
    logic       prev_en   = 1'b0;
    logic [7:0] rise_addrs [$];
    logic [1:0] rise_sizes [$];

    mem_access_ctrl dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .req        (req),
        .we         (we),
        .addr       (addr),
        .size       (size),
        .wdata      (wdata),
        .rdata      (rdata),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .mem_enable (mem_enable),
        .mem_rw     (mem_rw),
        .mem_addr   (mem_addr),
        .mem_size   (mem_size),
        .mem_din    (mem_din),
        .mem_dout   (mem_dout),
        .mfc        (mfc)
    );

    always #5 clk = ~clk;

    // RAM model: big-endian, partial reads leave stale upper DataOut bits
    always @(posedge clk) begin
        if (!mfc) begin
            if (mem_enable && !ram_hang) begin
                if (dly == 0) begin
                    if (!mem_rw) begin
                        case (mem_size)
                            2'b00: ram[mem_addr] <= mem_din[7:0];
                            2'b01: begin
                                ram[mem_addr]      <= mem_din[15:8];
                                ram[mem_addr + 1]  <= mem_din[7:0];
                            end
                            default: begin
                                ram[mem_addr]      <= mem_din[31:24];
                                ram[mem_addr + 1]  <= mem_din[23:16];
                                ram[mem_addr + 2]  <= mem_din[15:8];
                                ram[mem_addr + 3]  <= mem_din[7:0];
                            end
                        endcase
                    end else begin
                        case (mem_size)
                            2'b00: mem_dout[7:0] <= ram[mem_addr];
                            2'b01: mem_dout[15:0] <= {ram[mem_addr],
                                                      ram[mem_addr + 1]};
                            default: mem_dout <= {ram[mem_addr],
                                                  ram[mem_addr + 1],
                                                  ram[mem_addr + 2],
                                                  ram[mem_addr + 3]};
                        endcase
                    end
                    mfc <= 1'b1;
                    dly <= int'($urandom_range(1, 20));
                end else begin
                    dly <= dly - 1;
                end
            end else begin
                dly <= int'($urandom_range(1, 20));
            end
        end else if (!mem_enable) begin
            if (dly == 0) mfc <= 1'b0;
            else          dly <= dly - 1;
        end
    end

    always @(posedge clk) begin
        if (mem_enable && !prev_en) begin
            rise_cnt = rise_cnt + 1;
            rise_addrs.push_back(mem_addr);
            rise_sizes.push_back(mem_size);
            if (mfc) bad_rise = bad_rise + 1;
        end
        prev_en = mem_enable;
        if (done) done_cnt = done_cnt + 1;
    end

    `define CHK(tag, obs, exp) begin checks++; assert ((obs) === (exp)) else begin failures++; $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp); end end

    task automatic op(input logic w, input logic [7:0] a,
                      input logic [1:0] s, input logic [63:0] d,
                      output int lat, output logic ok,
                      output logic err_seen);
        @(negedge clk);
        req = 1'b1; we = w; addr = a; size = s; wdata = d;
        @(negedge clk);
        req = 1'b0;
        lat = 1; ok = 1'b0; err_seen = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (done) begin
                ok = 1'b1;
                err_seen = err;
                break;
            end
            @(negedge clk);
            lat++;
        end
        if (!ok) $display("FAIL op_timeout addr=%0h no done within bound", a);
        @(negedge clk);
    endtask

    int          lat;
    logic        ok;
    logic        es;
    int          d0;
    int          r0;
    logic [31:0] w32;
    logic [63:0] w64;
    logic        got_en;

    initial begin
        for (int i = 0; i < 256; i++) ram[i] = 8'h00;
        mfc = 1'b0; mem_dout = '0; dly = 1; ram_hang = 1'b0;
        reset_n = 1'b0; req = 1'b0; we = 1'b0;
        addr = '0; size = '0; wdata = '0;
        repeat (3) @(negedge clk);

        `CHK("rst_busy", busy, 1'b0)
        `CHK("rst_done", done, 1'b0)
        `CHK("rst_err", err, 1'b0)
        `CHK("rst_enable", mem_enable, 1'b0)
        `CHK("rst_rw", mem_rw, 1'b0)
        `CHK("rst_rdata", rdata, 64'h0)
        reset_n = 1'b1;

        d0 = done_cnt;
        op(1'b1, 8'h10, 2'b10, 64'h0000_0000_DEAD_BEEF, lat, ok, es);
        `CHK("wr_word_ok", ok, 1'b1)
        `CHK("wr_word_done1", done_cnt - d0, 1)
        `CHK("wr_word_err", es, 1'b0)
        w32 = {ram[8'h10], ram[8'h11], ram[8'h12], ram[8'h13]};
        `CHK("wr_word_ram", w32, 32'hDEADBEEF)

        d0 = done_cnt;
        op(1'b0, 8'h10, 2'b10, 64'h0, lat, ok, es);
        `CHK("rd_word_done1", done_cnt - d0, 1)
        `CHK("rd_word_rdata", rdata, 64'h0000_0000_DEAD_BEEF)

        op(1'b0, 8'h11, 2'b00, 64'h0, lat, ok, es);
        `CHK("rd_byte_rdata", rdata, 64'h0000_0000_0000_00AD)

        r0 = rise_addrs.size();
        op(1'b1, 8'hF8, 2'b11, 64'h0123_4567_89AB_CDEF, lat, ok, es);
        `CHK("wr_dw_rises", rise_addrs.size() - r0, 2)
        `CHK("wr_dw_addr0", rise_addrs[r0], 8'hF8)
        `CHK("wr_dw_addr1", rise_addrs[r0 + 1], 8'hFC)
        `CHK("wr_dw_size0", rise_sizes[r0], 2'b10)
        `CHK("wr_dw_size1", rise_sizes[r0 + 1], 2'b10)
        w64 = {ram[8'hF8], ram[8'hF9], ram[8'hFA], ram[8'hFB],
               ram[8'hFC], ram[8'hFD], ram[8'hFE], ram[8'hFF]};
        `CHK("wr_dw_ram", w64, 64'h0123_4567_89AB_CDEF)

        r0 = rise_addrs.size();
        op(1'b0, 8'hF8, 2'b11, 64'h0, lat, ok, es);
        `CHK("rd_dw_rises", rise_addrs.size() - r0, 2)
        `CHK("rd_dw_rdata", rdata, 64'h0123_4567_89AB_CDEF)
        `CHK("dw_no_stale_mfc", bad_rise, 0)

        r0 = rise_cnt;
        op(1'b0, 8'h21, 2'b01, 64'h0, lat, ok, es);
        `CHK("mis_half_ok", ok, 1'b1)
        `CHK("mis_half_lat", lat, 1)
        `CHK("mis_half_err", es, 1'b1)
        `CHK("mis_half_noen", rise_cnt - r0, 0)
        `CHK("mis_half_rdata", rdata, 64'h0123_4567_89AB_CDEF)

        @(negedge clk);
        req = 1'b1; we = 1'b0; addr = 8'h10; size = 2'b10;
        @(negedge clk);
        req = 1'b0;
        got_en = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (mem_enable) begin
                got_en = 1'b1;
                break;
            end
            @(negedge clk);
        end
        `CHK("rst_mid_enable", got_en, 1'b1)
        `CHK("rst_mid_busy_pre", busy, 1'b1)
        d0 = done_cnt;
        reset_n = 1'b0;
        @(negedge clk);
        `CHK("rst_mid_en_low", mem_enable, 1'b0)
        `CHK("rst_mid_busy_low", busy, 1'b0)
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        `CHK("rst_mid_nodone", done_cnt - d0, 0)
        `CHK("rst_mid_rdata", rdata, 64'h0)

        op(1'b0, 8'h10, 2'b10, 64'h0, lat, ok, es);
        `CHK("post_rst_ok", ok, 1'b1)
        `CHK("post_rst_rdata", rdata, 64'h0000_0000_DEAD_BEEF)

`ifdef MEM_TIMEOUT_EN
        ram_hang = 1'b1;
        op(1'b0, 8'h20, 2'b10, 64'h0, lat, ok, es);
        `CHK("tmo_lat", lat, 66)
        `CHK("tmo_err", es, 1'b1)
        `CHK("tmo_enable", mem_enable, 1'b0)
        `CHK("tmo_busy", busy, 1'b0)
        `CHK("tmo_rdata", rdata, 64'h0000_0000_DEAD_BEEF)
        ram_hang = 1'b0;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
